// File: rtl/fadd_arb_pkg.sv
// fadd_arb_pkg: shared FSM states, flag positions and fadd constants
package fadd_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_e;
  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;
  localparam int FADD_LAT = 3;
  localparam logic [31:0] SIGN_MASK = 32'h8000_0000;
endpackage

// File: rtl/fadd_arb_if.sv
// fadd_arb_if: requester, result and fadd-side signals of the shared adder arbiter
interface fadd_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW = 2
);
  logic [NREQ-1:0] in_valid;
  logic [NREQ-1:0] in_ready;
  logic [NREQ-1:0] in_sub;
  logic [32*NREQ-1:0] in_x;
  logic [32*NREQ-1:0] in_y;
  logic out_valid;
  logic out_ready;
  logic [IDW-1:0] out_id;
  logic [31:0] out_rslt;
  logic [4:0] out_flag;
  logic [4:0] fflags;
  logic fflags_clr;
  logic busy;
  logic fadd_req;
  logic [31:0] fadd_x;
  logic [31:0] fadd_y;
  logic [31:0] fadd_rslt;
  logic [4:0] fadd_flag;
  modport master (
    output in_valid, in_sub, in_x, in_y, out_ready, fflags_clr, fadd_rslt, fadd_flag,
    input in_ready, out_valid, out_id, out_rslt, out_flag, fflags, busy, fadd_req, fadd_x, fadd_y
  );
  modport slave (
    input in_valid, in_sub, in_x, in_y, out_ready, fflags_clr, fadd_rslt, fadd_flag,
    output in_ready, out_valid, out_id, out_rslt, out_flag, fflags, busy, fadd_req, fadd_x, fadd_y
  );
endinterface

// File: rtl/fadd_arb_rr_arb.sv
// fadd_arb_rr_arb: combinational round-robin pick, searching cyclically from ptr+1
module fadd_arb_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);
  logic [IDW-1:0] k;
  // Walk from the farthest candidate back to ptr+1 so the nearest request wins last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = IDW'((int'(ptr_i) + i) % NREQ);
      if (req_i[k]) begin
        gnt_o = '0;
        gnt_o[k] = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/fadd.sv
// fadd_arb: shares one fadd among NREQ requesters with round-robin grant,
// optional subtract, tagged results and sticky IEEE flags
module fadd_arb
  import fadd_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int LAT = FADD_LAT
) (
  input logic clk,
  input logic reset,
  fadd_arb_if.slave bus
);
  localparam int CW = $clog2(LAT + 1);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, out_id_q, out_id_d, idx;
  logic [NREQ-1:0] gnt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] fadd_x_q, fadd_x_d, fadd_y_q, fadd_y_d, out_rslt_q, out_rslt_d;
  logic [4:0] out_flag_q, out_flag_d, fflags_q, fflags_d;
  logic fadd_req_q, fadd_req_d, out_valid_q, out_valid_d, busy_q, busy_d;
  logic hs_in, hs_out, capt;

  fadd_arb_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i(bus.in_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE  ? (|bus.in_valid ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? (cnt_q == CW'(1) ? CAPT : WAIT) :
              state_q == CAPT  ? RESP :
              (bus.out_ready ? IDLE : RESP);
  end

  // The fadd operands only change on a grant, which keeps them stable from ISSUE through CAPT.
  always_comb begin
    hs_in = state_q == IDLE && |bus.in_valid;
    hs_out = state_q == RESP && bus.out_ready;
    capt = state_q == CAPT;
    ptr_d = hs_in ? idx : ptr_q;
    fadd_x_d = hs_in ? bus.in_x[32*idx +: 32] : fadd_x_q;
    fadd_y_d = hs_in ? bus.in_y[32*idx +: 32] ^ (bus.in_sub[idx] ? SIGN_MASK : '0) : fadd_y_q;
    fadd_req_d = hs_in;
    cnt_d = state_q == ISSUE ? CW'(LAT - 1) : state_q == WAIT ? cnt_q - CW'(1) : cnt_q;
    out_rslt_d = capt ? bus.fadd_rslt : out_rslt_q;
    out_flag_d = capt ? bus.fadd_flag : out_flag_q;
    out_id_d = capt ? ptr_q : out_id_q;
    out_valid_d = capt ? 1'b1 : hs_out ? 1'b0 : out_valid_q;
    fflags_d = (bus.fflags_clr ? 5'b0 : fflags_q) | (hs_out ? out_flag_q : 5'b0);
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= IDW'(NREQ - 1);
      cnt_q <= '0;
      fadd_x_q <= '0;
      fadd_y_q <= '0;
      fadd_req_q <= 1'b0;
      out_rslt_q <= '0;
      out_flag_q <= '0;
      out_id_q <= '0;
      out_valid_q <= 1'b0;
      fflags_q <= '0;
      busy_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      fadd_x_q <= fadd_x_d;
      fadd_y_q <= fadd_y_d;
      fadd_req_q <= fadd_req_d;
      out_rslt_q <= out_rslt_d;
      out_flag_q <= out_flag_d;
      out_id_q <= out_id_d;
      out_valid_q <= out_valid_d;
      fflags_q <= fflags_d;
      busy_q <= busy_d;
    end
  end

  assign bus.in_ready = hs_in ? gnt : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id = out_id_q;
  assign bus.out_rslt = out_rslt_q;
  assign bus.out_flag = out_flag_q;
  assign bus.fflags = fflags_q;
  assign bus.busy = busy_q;
  assign bus.fadd_req = fadd_req_q;
  assign bus.fadd_x = fadd_x_q;
  assign bus.fadd_y = fadd_y_q;
endmodule

// File: tb/tb_fadd_arb.sv
// tb_fadd_arb: directed and randomized checks of fadd_arb against a transaction-level model
module tb_fadd_arb;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fadd_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus();
  fadd_arb #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

  int passed = 0;
  int total = 0;
  int fails = 0;
  int m_ptr;
  logic [4:0] m_ff;

  // Stand-in adder: known IEEE cases by table, otherwise an arbitrary deterministic mix.
  function automatic logic [36:0] fadd_fn(input logic [31:0] x, input logic [31:0] y);
    case ({x, y})
      {32'h3f800000, 32'h40000000}: return {32'h40400000, 5'b00000};
      {32'h3f800000, 32'hbf800000}: return {32'h00000000, 5'b00000};
      {32'h7f800000, 32'hff800000}: return {32'hffc00000, 5'b10000};
      {32'h7f7fffff, 32'h7f7fffff}: return {32'h7f800000, 5'b00101};
      default: return {x + y, x[4:0] ^ y[4:0]};
    endcase
  endfunction

  // fadd behaviour: result appears LAT cycles after req, only if operands were held.
  int age = 0;
  logic [31:0] sx, sy;
  always @(posedge clk) begin
    if (bus.fadd_req) begin
      age <= 1;
      sx <= bus.fadd_x;
      sy <= bus.fadd_y;
    end else if (age != 0) age <= age + 1;
  end
  always_comb begin
    {bus.fadd_rslt, bus.fadd_flag} = (age == LAT && bus.fadd_x == sx && bus.fadd_y == sy) ?
      fadd_fn(bus.fadd_x, bus.fadd_y) : {32'hdeadbeef, 5'b11111};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 1; i <= NREQ; i++) if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic raise(input int k, input logic [31:0] x, input logic [31:0] y, input logic s);
    bus.in_x[32*k +: 32] = x;
    bus.in_y[32*k +: 32] = y;
    bus.in_sub[k] = s;
    bus.in_valid[k] = 1'b1;
  endtask

  task automatic txn(input int hold, input logic clr, input bit quick, output int g);
    int n, lat;
    logic [31:0] ex, ey;
    logic [36:0] r;
    bus.out_ready = (hold == 0);
    #1;
    n = 0;
    while (bus.in_ready == '0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      chk("grant_timeout", 64'(n), 64'(0));
      g = -1;
      return;
    end
    if (quick) chk("grant_next_cycle", 64'(n), 64'(0));
    g = pick(bus.in_valid, m_ptr);
    chk("in_ready", 64'(bus.in_ready), 64'(1 << g));
    ex = bus.in_x[32*g +: 32];
    ey = bus.in_y[32*g +: 32] ^ {bus.in_sub[g], 31'b0};
    r = fadd_fn(ex, ey);
    m_ptr = g;
    @(posedge clk);
    #1;
    bus.in_valid[g] = 1'b0;
    chk("issue_req_busy", 64'({bus.fadd_req, bus.busy, bus.in_ready}), 64'({2'b11, 4'b0}));
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT + 2));
    chk("out_id", 64'(bus.out_id), 64'(g));
    chk("out_rslt", 64'(bus.out_rslt), 64'(r[36:5]));
    chk("out_flag", 64'(bus.out_flag), 64'(r[4:0]));
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("backpressure_hold", 64'({bus.out_valid, bus.out_id, bus.out_rslt, bus.out_flag, bus.in_ready, bus.fadd_req}),
          64'({1'b1, IDW'(g), r, 4'b0, 1'b0}));
    end
    bus.out_ready = 1'b1;
    bus.fflags_clr = clr;
    @(posedge clk);
    #1;
    bus.fflags_clr = 1'b0;
    m_ff = (clr ? 5'b0 : m_ff) | r[4:0];
    chk("after_handshake", 64'({bus.out_valid, bus.fflags}), 64'({1'b0, m_ff}));
  endtask

  initial begin
    int g, n;
    bus.in_valid = '0;
    bus.in_x = '0;
    bus.in_y = '0;
    bus.in_sub = '0;
    bus.out_ready = 1'b1;
    bus.fflags_clr = 1'b0;
    m_ptr = NREQ - 1;
    m_ff = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 64'({bus.in_ready, bus.out_valid, bus.out_id, bus.out_rslt, bus.out_flag, bus.fflags, bus.busy, bus.fadd_req}), 64'(0));
    chk("reset_fadd_ops", {bus.fadd_x, bus.fadd_y}, 64'(0));
    reset = 1'b0;

    raise(0, 32'h3f800000, 32'h40000000, 1'b0);
    txn(0, 1'b0, 1'b0, g);
    chk("basic_id", 64'(g), 64'(0));
    chk("basic_rslt", 64'(bus.out_rslt), 64'(32'h40400000));

    raise(2, 32'h3f800000, 32'h3f800000, 1'b1);
    txn(0, 1'b0, 1'b0, g);
    chk("sub_rslt", 64'({bus.out_id, bus.out_rslt, bus.out_flag}), 64'({2'd2, 32'h0, 5'b0}));

    raise(1, 32'h7f800000, 32'h7f800000, 1'b1);
    txn(0, 1'b0, 1'b0, g);
    chk("inf_sub_nv", 64'({bus.out_rslt, bus.out_flag, bus.fflags}), 64'({32'hffc00000, 5'b10000, 5'b10000}));
    raise(3, 32'h7f7fffff, 32'h7f7fffff, 1'b0);
    txn(0, 1'b0, 1'b0, g);
    chk("overflow_sticky", 64'({bus.out_rslt, bus.out_flag, bus.fflags}), 64'({32'h7f800000, 5'b00101, 5'b10101}));
    bus.fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.fflags_clr = 1'b0;
    m_ff = '0;
    chk("fflags_clr", 64'(bus.fflags), 64'(0));

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ptr = NREQ - 1;
    for (int k = 0; k < NREQ; k++) raise(k, $urandom, $urandom, 1'($urandom_range(1)));
    for (int i = 0; i < NREQ; i++) begin
      txn(0, 1'b0, i > 0, g);
      chk("rr_order", 64'(g), 64'(i));
    end
    raise(0, $urandom, $urandom, 1'b0);
    txn(0, 1'b0, 1'b0, g);
    chk("rr_wrap", 64'(g), 64'(0));

    raise(1, $urandom, $urandom, 1'b0);
    raise(2, $urandom, $urandom, 1'b1);
    txn(10, 1'b0, 1'b0, g);
    chk("bp_grant", 64'(g), 64'(1));
    txn(0, 1'b0, 1'b1, g);
    chk("bp_next_grant", 64'(g), 64'(2));

    raise(3, 32'h7f800000, 32'h7f800000, 1'b1);
    txn(0, 1'b1, 1'b0, g);
    chk("clr_or_wins", 64'(bus.fflags), 64'(5'b10000));

    raise(0, 32'h3f800000, 32'h40000000, 1'b0);
    #1;
    n = 0;
    while (bus.in_ready == '0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midop_grant", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midop_reset", 64'({bus.out_valid, bus.busy, bus.fflags}), 64'(0));
    m_ptr = NREQ - 1;
    m_ff = '0;
    raise(0, 32'h3f800000, 32'h40000000, 1'b0);
    txn(0, 1'b0, 1'b0, g);
    chk("post_reset_rslt", 64'(bus.out_rslt), 64'(32'h40400000));

    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NREQ; k++)
        if (!bus.in_valid[k] && $urandom_range(1) == 1) raise(k, $urandom, $urandom, 1'($urandom_range(1)));
      if (bus.in_valid == '0) raise(int'($urandom_range(NREQ - 1)), $urandom, $urandom, 1'($urandom_range(1)));
      txn(int'($urandom_range(3)), 1'($urandom_range(1)), 1'b0, g);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
